// File: rtl/chess_pkg.sv
// Shared definitions for the board_update slice.
// Purpose: piece encodings, the starting position, the board_update FSM state
// type and a small colour helper used by every file of the board logic.
// Contents:
//   PIECE_EMPTY, PAWN..KING  4-bit piece codes, bit BLACK_BIT set for black
//   board_t                  [row][col] packed board, row 0 is the top rank
//   INIT_BOARD               standard start: rows 0-1 black, rows 6-7 white
//   board_state_t            IDLE / HELD / COMMIT
//   is_black()               colour test on a piece code
package chess_pkg;

  localparam int unsigned BLACK_BIT = 3;

  localparam logic [3:0] PIECE_EMPTY = 4'd0;
  localparam logic [3:0] PAWN        = 4'd1;
  localparam logic [3:0] KNIGHT      = 4'd2;
  localparam logic [3:0] BISHOP      = 4'd3;
  localparam logic [3:0] ROOK        = 4'd4;
  localparam logic [3:0] QUEEN       = 4'd5;
  localparam logic [3:0] KING        = 4'd6;
  localparam logic [3:0] BLACK_MASK  = 4'(1 << BLACK_BIT);

  typedef logic [0:7][0:7][3:0] board_t;

  // Each row is eight 4-bit codes, column 0 leftmost; rows are listed top first.
  localparam board_t INIT_BOARD = {
    {ROOK | BLACK_MASK, KNIGHT | BLACK_MASK, BISHOP | BLACK_MASK, QUEEN | BLACK_MASK,
     KING | BLACK_MASK, BISHOP | BLACK_MASK, KNIGHT | BLACK_MASK, ROOK | BLACK_MASK},
    {8{PAWN | BLACK_MASK}},
    {8{PIECE_EMPTY}},
    {8{PIECE_EMPTY}},
    {8{PIECE_EMPTY}},
    {8{PIECE_EMPTY}},
    {8{PAWN}},
    {ROOK, KNIGHT, BISHOP, QUEEN, KING, BISHOP, KNIGHT, ROOK}
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    COMMIT = 2'd2
  } board_state_t;

  function automatic logic is_black(input logic [3:0] piece);
    return piece[BLACK_BIT];
  endfunction

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector for a level request line.
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   level     request level from the front end
//   rise      one-cycle pulse, registered, after each 0->1 transition of level
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic level_q, level_d;
  logic rise_q, rise_d;

  // Compare the incoming level against last cycle's copy; a level that stays
  // high produces only the first pulse.
  always_comb begin
    level_d = level;
    rise_d  = level & ~level_q;
  end

  // History and pulse registers; reset clears both so a level already high
  // when reset releases still counts as a fresh request.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/board_update.sv
// Authoritative chess board state and pick/place sequencer.
// Purpose: turns pick/place requests at the cursor square into committed moves,
// tracks whose turn it is and reports the last move for highlighting.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   pick_piece      level; rising edge requests a pick at mouse_position
//   place_piece     level; rising edge requests a place at mouse_position
//   mouse_position  cursor square, [5:3] row (0 = top), [2:0] column
//   board           registered 8x8 board of 4-bit piece codes
//   white_turn      1 = white to move
//   holding         a piece is lifted; held_square is its source
//   move_done       one-cycle pulse when a move is committed
//   reject          one-cycle pulse on an illegal pick or place
//   last_src/last_dst/captured  last committed move and the piece it removed
//   move_count      committed half-moves, saturating
// Option: define BOARD_UPDATE_PROMOTION_EN to turn pawns reaching the far rank
// into queens of the same colour at commit time.
module board_update
  import chess_pkg::*;
#(
  parameter bit          WHITE_FIRST = 1'b1,
  parameter int unsigned CNT_W       = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pick_piece,
  input  logic             place_piece,
  input  logic [5:0]       mouse_position,
  output board_t           board,
  output logic             white_turn,
  output logic             holding,
  output logic [5:0]       held_square,
  output logic             move_done,
  output logic             reject,
  output logic [5:0]       last_src,
  output logic [5:0]       last_dst,
  output logic [3:0]       captured,
  output logic [CNT_W-1:0] move_count
);

  logic pick_rise, place_rise;

  edge_rise u_pick_edge (
    .clk   (clk),
    .rst   (rst),
    .level (pick_piece),
    .rise  (pick_rise)
  );

  edge_rise u_place_edge (
    .clk   (clk),
    .rst   (rst),
    .level (place_piece),
    .rise  (place_rise)
  );

  board_state_t     state_q, state_d;
  board_t           board_q, board_d;
  logic             white_turn_q, white_turn_d;
  logic             holding_q, holding_d;
  logic [5:0]       src_q, src_d;
  logic [5:0]       dst_q, dst_d;
  logic [3:0]       piece_q, piece_d;
  logic             move_done_q, move_done_d;
  logic             reject_q, reject_d;
  logic [5:0]       last_src_q, last_src_d;
  logic [5:0]       last_dst_q, last_dst_d;
  logic [3:0]       captured_q, captured_d;
  logic [CNT_W-1:0] move_count_q, move_count_d;

  logic [3:0] cursor_piece;
  logic [3:0] placed_piece;

  // Piece under the cursor, used both to validate a pick and to test a
  // destination for a same-colour occupant.
  assign cursor_piece = board_q[mouse_position[5:3]][mouse_position[2:0]];

  // Piece actually written at the destination; pawns reaching the far rank
  // become queens only when promotion is built in.
  always_comb begin
    placed_piece = piece_q;
`ifdef BOARD_UPDATE_PROMOTION_EN
    if (piece_q == PAWN && dst_q[5:3] == 3'd0) begin
      placed_piece = QUEEN;
    end else if (piece_q == (PAWN | BLACK_MASK) && dst_q[5:3] == 3'd7) begin
      placed_piece = QUEEN | BLACK_MASK;
    end
`endif
  end

  // Next-state logic. Only the request relevant to the current state is looked
  // at, so a simultaneous pick and place resolves to one action. The board is
  // only ever written in COMMIT, with the captured piece read before overwrite.
  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    white_turn_d = white_turn_q;
    holding_d    = holding_q;
    src_d        = src_q;
    dst_d        = dst_q;
    piece_d      = piece_q;
    move_done_d  = 1'b0;
    reject_d     = 1'b0;
    last_src_d   = last_src_q;
    last_dst_d   = last_dst_q;
    captured_d   = captured_q;
    move_count_d = move_count_q;

    unique case (state_q)
      IDLE: begin
        if (pick_rise) begin
          if (cursor_piece != PIECE_EMPTY && is_black(cursor_piece) != white_turn_q) begin
            src_d     = mouse_position;
            piece_d   = cursor_piece;
            holding_d = 1'b1;
            state_d   = HELD;
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      HELD: begin
        if (place_rise) begin
          if (mouse_position == src_q) begin
            holding_d = 1'b0;
            state_d   = IDLE;
          end else if (cursor_piece != PIECE_EMPTY &&
                       is_black(cursor_piece) == is_black(piece_q)) begin
            reject_d = 1'b1;
          end else begin
            dst_d   = mouse_position;
            state_d = COMMIT;
          end
        end
      end

      COMMIT: begin
        captured_d = board_q[dst_q[5:3]][dst_q[2:0]];
        board_d[dst_q[5:3]][dst_q[2:0]] = placed_piece;
        board_d[src_q[5:3]][src_q[2:0]] = PIECE_EMPTY;
        last_src_d   = src_q;
        last_dst_d   = dst_q;
        white_turn_d = ~white_turn_q;
        move_done_d  = 1'b1;
        holding_d    = 1'b0;
        if (move_count_q != {CNT_W{1'b1}}) begin
          move_count_d = move_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        holding_d = 1'b0;
      end
    endcase
  end

  // State registers; reset abandons any lifted piece and restores the start
  // position and the configured side to move.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      board_q      <= INIT_BOARD;
      white_turn_q <= WHITE_FIRST;
      holding_q    <= 1'b0;
      src_q        <= '0;
      dst_q        <= '0;
      piece_q      <= PIECE_EMPTY;
      move_done_q  <= 1'b0;
      reject_q     <= 1'b0;
      last_src_q   <= '0;
      last_dst_q   <= '0;
      captured_q   <= PIECE_EMPTY;
      move_count_q <= '0;
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      white_turn_q <= white_turn_d;
      holding_q    <= holding_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      piece_q      <= piece_d;
      move_done_q  <= move_done_d;
      reject_q     <= reject_d;
      last_src_q   <= last_src_d;
      last_dst_q   <= last_dst_d;
      captured_q   <= captured_d;
      move_count_q <= move_count_d;
    end
  end

  assign board       = board_q;
  assign white_turn  = white_turn_q;
  assign holding     = holding_q;
  assign held_square = src_q;
  assign move_done   = move_done_q;
  assign reject      = reject_q;
  assign last_src    = last_src_q;
  assign last_dst    = last_dst_q;
  assign captured    = captured_q;
  assign move_count  = move_count_q;

endmodule

// File: doc/board_update.md
Name: board_update

Overview:
- Responder to the cursor/pick-place front end: consumes the pick_piece/place_piece level handshake and the cursor square index.
- Owns the authoritative 8x8 board state and whose turn it is.
- Executes legal pick/cancel/place sequences and reports the last move for highlighting.
- Sits between the cursor/selection logic and the board renderer and move generator.

Parameters:
- WHITE_FIRST, 1, side to move after reset (1 = white, 0 = black).
- CNT_W, 10, width of the half-move counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pick_piece  in  1  level; rising edge requests pick at mouse_position
- place_piece  in  1  level; rising edge requests place at mouse_position
- mouse_position  in  6  cursor square; [5:3] row 0..7 (row 0 = top), [2:0] column
- board  out  4 x [0:7][0:7]  current board, registered
- white_turn  out  1  1 = white to move
- holding  out  1  piece currently lifted
- held_square  out  6  source square of the lifted piece
- move_done  out  1  one-cycle pulse when a move is committed
- reject  out  1  one-cycle pulse on an illegal pick or place
- last_src  out  6  source square of the last committed move
- last_dst  out  6  destination square of the last committed move
- captured  out  4  piece removed by the last move (0 = none)
- move_count  out  CNT_W  committed half-moves, saturating

Behaviour:
- Piece code: 0 empty; 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king; bit3 = 1 marks black.
- Reset (sync, rst high at posedge clk):
  - board = INIT_BOARD: rows 0-1 black, rows 6-7 white, standard layout.
  - white_turn = WHITE_FIRST.
  - holding, move_done, reject = 0.
  - held_square, last_src, last_dst, captured, move_count = 0.
  - Any operation in progress is abandoned; reset mid-operation restores the initial board.
- Edge detection: pick_piece and place_piece are registered once; action is taken on the 0->1 transition only. Levels held high are ignored.
- FSM states: IDLE, HELD, COMMIT.
  - IDLE, pick edge:
    - Square non-empty and colour matches white_turn: latch src = mouse_position and piece = board[src]; holding = 1; go to HELD.
    - Otherwise: reject pulse, stay in IDLE.
    - Place edges in IDLE are ignored without a reject pulse.
  - HELD, place edge:
    - dst == src: cancel; holding = 0; go to IDLE; no turn change, no pulse.
    - dst holds a piece of the mover's own colour: reject pulse, stay in HELD.
    - Otherwise: latch dst; go to COMMIT.
    - Pick edges in HELD are ignored.
  - COMMIT (exactly one cycle):
    - board[dst] = piece; board[src] = 0.
    - captured = old board[dst]; last_src = src; last_dst = dst.
    - Toggle white_turn; move_done = 1; holding = 0.
    - move_count increments, saturating at all-ones.
    - Return to IDLE.
- Latency: board updated and move_done high 2 cycles after the registered place edge (edge-detect register, then COMMIT).
- Simultaneous pick and place edges: only the edge relevant to the current state is acted on.
- No move-legality checking beyond colour and ownership; destination legality is the front end's responsibility.

Optional Feature:
- Macro: BOARD_UPDATE_PROMOTION_EN.
- Defined: during COMMIT, a white pawn (1) landing on row 0 is written as white queen (5), and a black pawn (9) landing on row 7 is written as black queen (13).
- Undefined: the pawn code is written unchanged.

Decomposition:
- chess_pkg holds:
  - piece constants PIECE_EMPTY, PAWN..KING and the BLACK_BIT index;
  - the INIT_BOARD constant;
  - the board_state_t FSM enum;
  - helper function is_black(piece).
- Sub-module edge_rise (1-bit registered rising-edge detector), instantiated twice.

Test Plan:
- Reset, then pick edge at square 52 (white pawn), place edge at 36 -> board[4][4]=1, board[6][4]=0, move_done pulse, white_turn=0, move_count=1, last_src=52, last_dst=36.
- After reset, pick edge at 12 (black pawn) while white to move -> reject pulse, holding stays 0, board unchanged.
- Pick 52, place 52 -> holding returns to 0, no move_done, white_turn still 1, move_count 0.
- Pick 60 (white king), place 59 (white queen) -> reject pulse, holding stays 1; then place 44 (empty) -> commit, board[5][4]=6.
- Capture: after arranging a white pawn on 20 and black to move... white pawn at 20 lifted on white's turn, place on 11 (black pawn 9) -> captured=9, board[1][3]=1.
- With BOARD_UPDATE_PROMOTION_EN: white pawn on 8 placed on 0 -> board[0][0]=5. Assert rst mid-HELD -> holding=0 and INIT_BOARD restored next cycle.
